// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the single-ported memory.
// Port 0 is instruction fetch and port 1 is load/store. Each access strobes memory for one cycle, then pulses ready.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ready,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ready,
    output logic [DW-1:0] p1_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_r;
    logic          owner_r;
    logic          last_r;
    logic          mem_read_r;
    logic          mem_write_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;

    logic          elig0_s;
    logic          elig1_s;
    logic          grant_s;
    logic          winner_s;
    logic          win_we_s;
    logic [AW-1:0] win_addr_s;
    logic [DW-1:0] win_wdata_s;

    // Eligibility and round-robin winner; the owner in RESP still holds req and must be masked
    always_comb begin
        elig0_s     = p0_req && !((state_r == RESP) && (owner_r == 1'b0));
        elig1_s     = p1_req && !((state_r == RESP) && (owner_r == 1'b1));
        grant_s     = elig0_s || elig1_s;
        if (elig0_s && elig1_s) begin
            winner_s = ~last_r;
        end else begin
            winner_s = elig1_s;
        end
        if (winner_s) begin
            win_we_s    = p1_we;
            win_addr_s  = p1_addr;
            win_wdata_s = p1_wdata;
        end else begin
            win_we_s    = p0_we;
            win_addr_s  = p0_addr;
            win_wdata_s = p0_wdata;
        end
    end

    // Arbitration FSM with registered memory strobes, address and write data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            owner_r     <= 1'b0;
            last_r      <= 1'b1;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
        end else begin
            case (state_r)
                IDLE, RESP: begin
                    if (grant_s) begin
                        state_r     <= BUSY;
                        owner_r     <= winner_s;
                        last_r      <= winner_s;
                        mem_read_r  <= ~win_we_s;
                        mem_write_r <= win_we_s;
                        mem_addr_r  <= win_addr_s;
                        mem_wdata_r <= win_wdata_s;
                    end else begin
                        state_r     <= IDLE;
                        mem_read_r  <= 1'b0;
                        mem_write_r <= 1'b0;
                    end
                end
                BUSY: begin
                    state_r     <= RESP;
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                end
            endcase
        end
    end

    // Response steering: only the owner sees ready and data, and only while in RESP
    always_comb begin
        p0_ready = 1'b0;
        p1_ready = 1'b0;
        p0_rdata = {DW{1'b0}};
        p1_rdata = {DW{1'b0}};
        if (state_r == RESP) begin
            if (owner_r) begin
                p1_ready = 1'b1;
                p1_rdata = mem_rdata;
            end else begin
                p0_ready = 1'b1;
                p0_rdata = mem_rdata;
            end
        end else begin
            p0_ready = 1'b0;
            p1_ready = 1'b0;
        end
    end

    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a small registered memory model.
// Directed accesses push expected strobes and responses; a negedge monitor pops and compares them.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ready, p1_ready;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_data;
        logic [31:0] rdata;
        int          gap;
    } item_t;

    item_t strobe_q[$];
    item_t resp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int strobe_cyc = 0;
    int ready_cyc  = 0;

    logic [31:0] mem_arr [8];

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ready(p0_ready), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ready(p1_ready), .p1_rdata(p1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used for latency and spacing checks
    always @(posedge clk) cyc <= cyc + 1;

    // Registered memory: RAM words and peripheral words folded onto eight slots
    always @(posedge clk) begin
        if (mem_write) mem_arr[{mem_addr[31], mem_addr[3:2]}] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem_arr[{mem_addr[31], mem_addr[3:2]}];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic chk_data,
                        input logic [31:0] rdata, input int gap);
        item_t it;
        it.port = port; it.we = we; it.addr = addr; it.wdata = wdata;
        it.chk_data = chk_data; it.rdata = rdata; it.gap = gap;
        strobe_q.push_back(it);
        resp_q.push_back(it);
    endtask

    task automatic wait_done(input int port);
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((port == 0 && p0_ready) || (port == 1 && p1_ready)) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL ready_timeout: port %0d got no ready within 60 cycles", port);
        end
        @(posedge clk);
        #1;
        if (port == 0) p0_req = 1'b0; else p1_req = 1'b0;
    endtask

    task automatic access(input int port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
        if (port == 0) begin
            p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
        end
        wait_done(port);
    endtask

    // Monitor: pops expected strobes and responses whenever the DUT presents them
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mem_read && mem_write) chk("strobe_exclusive", 32'd1, 32'd0);
                if (mem_read || mem_write) begin
                    if (strobe_q.size() == 0) begin
                        chk("unexpected_strobe", {mem_addr}, 32'hFFFF_FFFF);
                    end else begin
                        it = strobe_q.pop_front();
                        chk("strobe_we", {31'd0, mem_write}, {31'd0, it.we});
                        chk("strobe_addr", mem_addr, it.addr);
                        if (it.we) chk("strobe_wdata", mem_wdata, it.wdata);
                    end
                    strobe_cyc = cyc;
                end
                if (p0_ready && p1_ready) chk("ready_exclusive", 32'd1, 32'd0);
                if (p0_ready || p1_ready) begin
                    if (resp_q.size() == 0) begin
                        chk("unexpected_ready", {31'd0, p1_ready}, 32'hFFFF_FFFF);
                    end else begin
                        it = resp_q.pop_front();
                        chk("ready_port", {31'd0, p1_ready}, it.port);
                        if (it.chk_data)
                            chk("rdata", (it.port == 1) ? p1_rdata : p0_rdata, it.rdata);
                        chk("other_rdata_zero", (it.port == 1) ? p0_rdata : p1_rdata, 32'd0);
                        chk("strobe_to_ready", cyc - strobe_cyc, 32'd1);
                        if (it.gap != 0) chk("ready_spacing", cyc - ready_cyc, it.gap);
                    end
                    ready_cyc = cyc;
                end
            end
        end
    end

    initial begin
        bit seen;
        reset = 1'b1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10; p0_wdata = 32'd0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h14; p1_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_ready", {30'd0, p1_ready, p0_ready}, 32'd0);
        chk("rst_p0_rdata", p0_rdata, 32'd0);
        chk("rst_p1_rdata", p1_rdata, 32'd0);

        // Tie after reset: port 0 first, port 1 two cycles later
        push(0, 1'b0, 32'h10, 32'd0, 1'b0, 32'd0, 0);
        push(1, 1'b0, 32'h14, 32'd0, 1'b0, 32'd0, 2);
        reset = 1'b0;
        fork
            wait_done(0);
            wait_done(1);
        join
        repeat (2) @(negedge clk);

        // Write then read back through the other port
        push(1, 1'b1, 32'h4, 32'hDEADBEEF, 1'b0, 32'd0, 0);
        access(1, 1'b1, 32'h4, 32'hDEADBEEF);
        push(0, 1'b0, 32'h4, 32'd0, 1'b1, 32'hDEADBEEF, 0);
        access(0, 1'b0, 32'h4, 32'd0);

        // Peripheral window
        push(1, 1'b1, 32'hFFF00000, 32'hAA, 1'b0, 32'd0, 0);
        access(1, 1'b1, 32'hFFF00000, 32'hAA);
        push(0, 1'b0, 32'hFFF00000, 32'd0, 1'b1, 32'hAA, 0);
        access(0, 1'b0, 32'hFFF00000, 32'd0);
        push(1, 1'b1, 32'hFFF00004, 32'h12345678, 1'b0, 32'd0, 0);
        access(1, 1'b1, 32'hFFF00004, 32'h12345678);
        @(negedge clk);

        // Fairness: both ports saturated, last served was port 1 so port 0 leads
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b0, 32'h4, 32'd0, 1'b1, 32'hDEADBEEF, (i == 0) ? 0 : 2);
            push(1, 1'b1, 32'h8, 32'h100 + i, 1'b0, 32'd0, 2);
        end
        fork
            for (int i = 0; i < 4; i++) access(0, 1'b0, 32'h4, 32'd0);
            for (int j = 0; j < 4; j++) access(1, 1'b1, 32'h8, 32'h100 + j);
        join
        repeat (2) @(negedge clk);

        // Reset while the write strobe is high: abandoned, then retried to completion
        push(1, 1'b1, 32'h8, 32'h55, 1'b0, 32'd0, 0);
        strobe_q.push_back(strobe_q[strobe_q.size() - 1]);
        fork
            access(1, 1'b1, 32'h8, 32'h55);
            begin
                seen = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (mem_write) begin
                        seen = 1'b1;
                        break;
                    end
                end
                chk("busy_seen", {31'd0, seen}, 32'd1);
                #2 reset = 1'b1;
                #1;
                chk("rst_busy_mem_write", {31'd0, mem_write}, 32'd0);
                chk("rst_busy_ready", {30'd0, p1_ready, p0_ready}, 32'd0);
                @(negedge clk);
                reset = 1'b0;
            end
        join

        for (int i = 0; i < 20 && (resp_q.size() != 0 || strobe_q.size() != 0); i++)
            @(negedge clk);
        chk("resp_q_empty", resp_q.size(), 32'd0);
        chk("strobe_q_empty", strobe_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the single-ported `memory` block (RAM plus the memory-mapped peripherals at 0xFFF00000–0xFFF00008) between an instruction-fetch port (port 0) and a load/store port (port 1). Each port uses a req/ready handshake. The arbiter drives the memory's `mem_read`/`mem_write`/`addr`/`write_data` strobes from registers for exactly one cycle per access, then returns `read_data` to the winning port. It sits between the CPU core and `memory`.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `clk` in 1: system clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `p0_req` in 1: port 0 request; held high with fields stable until `p0_ready`.
- `p0_we` in 1: port 0 write enable (0 = read).
- `p0_addr` in AW: port 0 byte address.
- `p0_wdata` in DW: port 0 write data.
- `p0_ready` out 1: one-cycle completion pulse for port 0.
- `p0_rdata` out DW: read data, valid while `p0_ready` = 1.
- `p1_req`, `p1_we`, `p1_addr`, `p1_wdata`, `p1_ready`, `p1_rdata`: same as port 0, for port 1.
- `mem_read` out 1: read strobe to memory.
- `mem_write` out 1: write strobe to memory.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data. Registered in memory; valid the cycle after the edge that sampled `mem_read`.

## Operation
- States:
  - IDLE: no access in flight.
  - BUSY: strobes driven.
  - RESP: data returned / ready pulsed.
- Registers:
  - `state`
  - `owner` (1 bit)
  - `last` (1 bit, port most recently served)
  - `mem_read`, `mem_write`, `mem_addr`, `mem_wdata`
- Eligibility: a port is eligible at an edge if its req = 1.
  - In RESP, the current owner is never eligible; its req is still high while it sees ready.
- Winner selection: if only one port is eligible, that port wins. If both are eligible, the port ≠ `last` wins (round-robin).
- IDLE edge:
  - Winner exists: load `mem_addr`/`mem_wdata` from the winner's fields, set `mem_read` = ~we and `mem_write` = we, `owner` = winner, `last` = winner, go to BUSY.
  - No winner: stay in IDLE.
- BUSY edge: clear `mem_read`/`mem_write`; go to RESP. `mem_addr`/`mem_wdata` hold their value.
- RESP (combinational): `p<owner>_ready` = 1 and `p<owner>_rdata` = `mem_rdata`; the other port's ready = 0.
- RESP edge:
  - Other port requesting: grant it directly (same loads as IDLE), go to BUSY.
  - Otherwise: go to IDLE.
- Non-owner `pN_rdata` is driven 0. On writes, `p<owner>_rdata` mirrors `mem_rdata` and is don't-care for the requester.
- Addresses and data pass unmodified; peripheral decode stays inside `memory`.
- At most one of `mem_read`/`mem_write` is ever high.

## Timing
- Reset values:
  - `state` = IDLE, `owner` = 0, `last` = 1 (port 0 wins the first tie).
  - `mem_read` = 0, `mem_write` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - Both `pN_ready` = 0 and both `pN_rdata` = 0.
- Latency: req sampled at edge k → strobes high during cycle k → memory acts at edge k+1 → ready pulses during cycle k+1. The requester may drop or change req at edge k+2.
- Each strobe is high for exactly one cycle per access.
- Throughput:
  - One access every 2 cycles while both ports are requesting (grants alternate 0,1,0,1).
  - A single port alone: one access every 3 cycles, since RESP → IDLE → BUSY.
- Simultaneous requests in IDLE: resolved by `last`; no port waits more than one other access.
- Requester drops req before ready: not allowed. Behaviour is undefined, but the arbiter must still complete the in-flight access and return to IDLE.
- Reset mid-operation (BUSY or RESP): strobes and ready drop immediately (asynchronous). No ready pulse follows; the in-flight access is abandoned. After release, the arbiter starts from IDLE with the reset register values.

## Test plan
- Reset: assert `reset` with both reqs high → all outputs 0. Deassert `reset` → `mem_read` is high for one cycle with `mem_addr` = `p0_addr`.
- Write then read: port 1 writes 0xDEADBEEF to 0x4 → `mem_write` is high exactly 1 cycle with `mem_addr` = 0x4 and `p1_ready` pulses 1 cycle later. Port 0 then reads 0x4 → `p0_rdata` = 0xDEADBEEF during the `p0_ready` cycle.
- Tie: both ports request at the same edge after reset → port 0 is served first; port 1 is granted at port 0's RESP edge; `p1_ready` pulses exactly 2 cycles after `p0_ready`.
- Fairness: both reqs held continuously for 8 accesses → ready order 0,1,0,1,…; the ready pulses are spaced 2 cycles apart.
- Peripherals: port 1 writes 0xAA to 0xFFF00000; port 0 reads 0xFFF00000 → `p0_rdata` = 0xAA. Port 1 writes 0x12345678 to 0xFFF00004 → `mem_addr` = 0xFFF00004 and `mem_wdata` = 0x12345678 during the strobe cycle.
- Reset during BUSY: assert `reset` mid-cycle while `mem_write` = 1 → `mem_write` drops before the next edge; no ready pulse occurs. After release, the retried request completes normally.
